// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor. It computes diff = a - b - bin, one full-subtractor
//   bit per clock, starting with the LSB. A single borrow flop carries the
//   borrow from each bit to the next, so no WIDTH-wide subtract path exists.
//
// Parameters
//   WIDTH  operand width in bits (2..32)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request an operation; sampled only while idle
//   a, b   minuend and subtrahend; captured when start is accepted
//   bin    borrow-in; captured when start is accepted
//   busy   high while bits are being processed
//   done   one-cycle pulse when diff/bout hold a new result
//   diff   registered difference; held until the next completion
//   bout   registered borrow-out; held with diff
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // The counter holds values 0..WIDTH, so it never wraps during an operation.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       step;   // {borrow_next, diff_bit}
  logic             last;

  // One full-subtractor bit: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_step(input logic x, input logic y,
                                         input logic bi);
    logic d, bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

  always_comb begin
    step    = fs_step(a_sh[0], b_sh[0], br);
    last    = (cnt == LAST);
    state_d = state_q;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The result register fills from the MSB end, so after WIDTH steps the first
  // computed (LSB) bit has arrived at bit 0. diff is written only on the last
  // step, which keeps partial results off the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= step[1];
          res  <= {step[0], res[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            diff <= {step[0], res[WIDTH-1:1]};
            bout <= step[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  // Two 8-bit instances (the random sweep is split between them) and one 2-bit.
  logic       start8 [2];
  logic [7:0] a8     [2];
  logic [7:0] b8     [2];
  logic       bin8   [2];
  logic       busy8  [2];
  logic       done8  [2];
  logic [7:0] diff8  [2];
  logic       bout8  [2];

  logic       start2, bin2, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8_0 (
    .clk(clk), .rst(rst), .start(start8[0]), .a(a8[0]), .b(b8[0]),
    .bin(bin8[0]), .busy(busy8[0]), .done(done8[0]), .diff(diff8[0]),
    .bout(bout8[0])
  );

  serial_subtractor #(.WIDTH(8)) dut8_1 (
    .clk(clk), .rst(rst), .start(start8[1]), .a(a8[1]), .b(b8[1]),
    .bin(bin8[1]), .busy(busy8[1]), .done(done8[1]), .diff(diff8[1]),
    .bout(bout8[1])
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .bin(bin2), .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  // Issue one operation on an 8-bit instance; lat is the number of cycles
  // from the cycle after acceptance until done is seen (-1 on timeout).
  task automatic run8(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic bi, output logic [7:0] d, output logic bo,
                      output int lat);
    @(negedge clk);
    a8[idx] = a; b8[idx] = b; bin8[idx] = bi; start8[idx] = 1'b1;
    @(negedge clk);
    start8[idx] = 1'b0;
    lat = 0;
    while (done8[idx] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = -1;
    d  = diff8[idx];
    bo = bout8[idx];
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                      output logic [1:0] d, output logic bo, output int lat);
    @(negedge clk);
    a2 = a; b2 = b; bin2 = bi; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = -1;
    d  = diff2;
    bo = bout2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start8[i] = 1'b0; a8[i] = 8'hA5; b8[i] = 8'h3C; bin8[i] = 1'b1;
    end
    start2 = 1'b0; a2 = 2'b11; b2 = 2'b01; bin2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy8[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy8[0]); end
    n_cmp++; if (done8[0] !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done8[0]); end
    n_cmp++; if (diff8[0] !== 8'h00) begin n_bad++; $display("FAIL reset_diff got=%h exp=00", diff8[0]); end
    n_cmp++; if (bout8[0] !== 1'b0) begin n_bad++; $display("FAIL reset_bout got=%b exp=0", bout8[0]); end
    n_cmp++; if ({busy2, done2, bout2, diff2} !== 5'b0) begin
      n_bad++; $display("FAIL reset_w2 got=%b exp=00000", {busy2, done2, bout2, diff2});
    end
  endtask

  // 0x5A - 0x3C = 0x1E; also checks latency, diff hold and pulse width.
  task automatic test_basic;
    int lat;
    bit hold_bad;
    @(negedge clk);
    a8[0] = 8'h5A; b8[0] = 8'h3C; bin8[0] = 1'b0; start8[0] = 1'b1;
    @(negedge clk);
    start8[0] = 1'b0;
    n_cmp++; if (busy8[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b exp=1", busy8[0]); end
    lat = 0; hold_bad = 1'b0;
    while (done8[0] !== 1'b1 && lat < 20) begin
      if (diff8[0] !== 8'h00 || bout8[0] !== 1'b0) hold_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (hold_bad) begin n_bad++; $display("FAIL basic_diff_hold got=partial exp=stable 00"); end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    n_cmp++; if (diff8[0] !== 8'h1E) begin n_bad++; $display("FAIL basic_diff got=%h exp=1e", diff8[0]); end
    n_cmp++; if (bout8[0] !== 1'b0) begin n_bad++; $display("FAIL basic_bout got=%b exp=0", bout8[0]); end
    @(negedge clk);
    n_cmp++; if (done8[0] !== 1'b0 || busy8[0] !== 1'b0) begin
      n_bad++; $display("FAIL basic_pulse got done=%b busy=%b exp=0/0", done8[0], busy8[0]);
    end
    n_cmp++; if (diff8[0] !== 8'h1E) begin n_bad++; $display("FAIL basic_held got=%h exp=1e", diff8[0]); end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  task automatic test_vectors;
    vec_t v[5];
    logic [7:0] d;
    logic bo;
    int lat;
    v[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    v[1] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    v[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v[3] = '{8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0};
    v[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run8(0, v[i].a, v[i].b, v[i].bi, d, bo, lat);
      n_cmp++;
      if (lat != 8 || d !== v[i].d || bo !== v[i].bo) begin
        n_bad++;
        $display("FAIL vector%0d got diff=%h bout=%b lat=%0d exp diff=%h bout=%b lat=8",
                 i, d, bo, lat, v[i].d, v[i].bo);
      end
    end
  endtask

  // start held high, operands changed mid-RUN: 0x33-0x11 first, then the
  // changed operands 0x10-0x20-1 = 0xEF with borrow on the second operation.
  task automatic test_back_to_back;
    int t1, t2;
    logic [7:0] d1, d2;
    logic bo1, bo2;
    t1 = -1; t2 = -1; d1 = 'x; d2 = 'x; bo1 = 1'bx; bo2 = 1'bx;
    @(negedge clk);
    a8[0] = 8'h33; b8[0] = 8'h11; bin8[0] = 1'b0; start8[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin a8[0] = 8'h10; b8[0] = 8'h20; bin8[0] = 1'b1; end
      if (done8[0] === 1'b1) begin
        if (t1 < 0) begin
          t1 = c; d1 = diff8[0]; bo1 = bout8[0];
        end else begin
          t2 = c; d2 = diff8[0]; bo2 = bout8[0];
          break;
        end
      end
    end
    start8[0] = 1'b0;
    n_cmp++; if (t1 != 9) begin n_bad++; $display("FAIL b2b_first_time got=%0d exp=9", t1); end
    n_cmp++; if (t2 - t1 != 10 || t2 < 0) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=10", t2 - t1); end
    n_cmp++; if (d1 !== 8'h22 || bo1 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first got diff=%h bout=%b exp diff=22 bout=0", d1, bo1);
    end
    n_cmp++; if (d2 !== 8'hEF || bo2 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second got diff=%h bout=%b exp diff=ef bout=1", d2, bo2);
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (busy8[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got busy=%b exp=0", busy8[0]); end
  endtask

  task automatic test_reset_abort;
    bit saw_done;
    logic [7:0] d;
    logic bo;
    int lat;
    saw_done = 1'b0;
    @(negedge clk);
    a8[0] = 8'h77; b8[0] = 8'h11; bin8[0] = 1'b0; start8[0] = 1'b1;
    @(negedge clk);
    start8[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy8[0] !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got=%b exp=1", busy8[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      if (done8[0] === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (saw_done) begin n_bad++; $display("FAIL abort_done got=pulse exp=none"); end
    n_cmp++; if (busy8[0] !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy8[0]); end
    n_cmp++; if (diff8[0] !== 8'h00 || bout8[0] !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs got diff=%h bout=%b exp diff=00 bout=0", diff8[0], bout8[0]);
    end
    run8(0, 8'h10, 8'h01, 1'b0, d, bo, lat);
    n_cmp++; if (lat != 8 || d !== 8'h0F || bo !== 1'b0) begin
      n_bad++; $display("FAIL abort_restart got diff=%h bout=%b lat=%0d exp diff=0f bout=0 lat=8", d, bo, lat);
    end
  endtask

  task automatic sweep8(input int idx, input int n);
    logic [7:0] a, b, d;
    logic bi, bo;
    logic [8:0] exp;
    int lat;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom_range(0, 1));
      exp = {1'b0, a} - {1'b0, b} - {8'b0, bi};
      run8(idx, a, b, bi, d, bo, lat);
      n_cmp++;
      if (lat != 8 || {bo, d} !== exp) begin
        n_bad++;
        $display("FAIL sweep8 a=%h b=%h bin=%b got diff=%h bout=%b lat=%0d exp diff=%h bout=%b",
                 a, b, bi, d, bo, lat, exp[7:0], exp[8]);
      end
    end
  endtask

  task automatic sweep2(input int n);
    logic [1:0] a, b, d;
    logic bi, bo;
    logic [2:0] exp;
    int lat;
    for (int i = 0; i < n; i++) begin
      a = 2'($urandom); b = 2'($urandom); bi = 1'($urandom_range(0, 1));
      exp = {1'b0, a} - {1'b0, b} - {2'b0, bi};
      run2(a, b, bi, d, bo, lat);
      n_cmp++;
      if (lat != 2 || {bo, d} !== exp) begin
        n_bad++;
        $display("FAIL sweep2 a=%h b=%h bin=%b got diff=%h bout=%b lat=%0d exp diff=%h bout=%b",
                 a, b, bi, d, bo, lat, exp[1:0], exp[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    fork
      sweep8(0, 5000);
      sweep8(1, 5000);
      sweep2(10000);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; captured on the accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; captured on the accepted start.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in; captured on the accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a result is valid.
REQ-010 The block SHALL have port diff, output, WIDTH bits: registered difference, held until the next completion.
REQ-011 The block SHALL have port bout, output, 1 bit: registered borrow-out, held with diff.

Function
REQ-012 The block SHALL compute one full-subtractor bit per clock, LSB first, using an internal borrow flip-flop; no WIDTH-wide subtract path is permitted.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL load shift registers with a and b, load the borrow flop with bin, clear the bit counter, and go to RUN.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE with all registers unchanged.
REQ-016 Each RUN cycle SHALL perform one bit step:
- d = a0 ^ b0 ^ br
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
- shift d into the MSB of the result register
- shift the a/b registers right by one
- increment the counter.
REQ-017 After the WIDTH-th RUN step (counter = WIDTH-1 during that step), the block SHALL go to DONE.
REQ-018 On the RUN-to-DONE transition, the block SHALL load diff with the completed result and load bout with the final borrow.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE unconditionally.
REQ-020 A start asserted in DONE SHALL be ignored.
REQ-021 A start asserted in RUN SHALL be ignored, and a, b and bin SHALL NOT affect an operation in progress.
REQ-022 Latency: with start accepted at edge T, done SHALL be high in the cycle after edge T+WIDTH (i.e. WIDTH+1 cycles after acceptance).
REQ-023 Throughput SHALL be one operation per WIDTH+2 cycles when start is held high.
REQ-024 Result arithmetic:
- diff = (a - b - bin) mod 2^WIDTH
- bout = 1 iff a < b + bin, evaluated as unsigned
REQ-025 diff and bout SHALL change only at the RUN-to-DONE transition or on reset; partial results SHALL never be visible on diff.
REQ-026 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap during an operation.

Reset
REQ-027 With rst=1 at a rising edge, the block SHALL set state=IDLE, counter=0, borrow flop=0, shift registers=0, busy=0, done=0, diff=0, bout=0.
REQ-028 rst SHALL take priority over start and over every FSM transition.
REQ-029 A reset asserted in RUN or DONE SHALL abort the operation without producing a done pulse, and diff and bout SHALL read 0 afterwards.
REQ-030 The first start accepted after reset is released SHALL behave as from a clean IDLE.

Verification
REQ-031 With WIDTH=8, a=0x5A, b=0x3C, bin=0, start accepted at edge T: done SHALL be high after edge T+8, with diff=0x1E and bout=0.
REQ-032 With a=0x00, b=0x01, bin=0: diff SHALL be 0xFF and bout SHALL be 1 (underflow wrap).
REQ-033 With a=0x80, b=0x7F, bin=1: diff SHALL be 0x00 and bout SHALL be 0; with a=0xFF, b=0xFF, bin=1: diff SHALL be 0xFF and bout SHALL be 1 (borrow propagates through every bit).
REQ-034 Start held high with a, b changed mid-RUN: only the values captured at acceptance SHALL be used, and back-to-back done pulses SHALL be exactly 10 cycles apart.
REQ-035 rst pulsed on the 4th RUN cycle: no done pulse SHALL occur, and busy, diff and bout SHALL be 0; a following start with a=0x10, b=0x01 SHALL give diff=0x0F and bout=0.
REQ-036 The bench SHALL run a random sweep of 10,000 operands for each of WIDTH=8 and WIDTH=2, checking every result against a behavioural model of REQ-024.
